// File: rtl/voter_bist_if.sv
// voter_bist_if: bundles the self-test control, voter stimulus/response and status signals.
//   start    : request a self-test sweep (level-sampled)
//   a,b,c,d  : stimulus pattern to the voter under test (a = MSB, d = LSB)
//   y        : voter output under test
//   busy     : sweep in progress
//   done     : sweep complete, results valid
//   pass     : done with zero mismatches
//   err_cnt  : number of mismatching patterns (0..16)
//   fail_vec : bit i set when pattern i mismatched
// master = the BIST engine, slave = the environment (voter under test plus controller).
interface voter_bist_if;
    logic        start;
    logic        a, b, c, d;
    logic        y;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [15:0] fail_vec;
    modport master (input start, y, output a, b, c, d, busy, done, pass, err_cnt, fail_vec);
    modport slave (output start, y, input a, b, c, d, busy, done, pass, err_cnt, fail_vec);
endinterface

// File: rtl/voter_bist.sv
// voter_bist: sweeps all 16 patterns into a 4-input majority voter and records mismatches.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : voter_bist_if.master (start, a..d, y, busy, done, pass, err_cnt, fail_vec)
// Each pattern is held DWELL cycles; y is sampled only on the last cycle of the hold.
module voter_bist #(
    parameter int unsigned DWELL = 10
) (
    input logic         clk,
    input logic         rst_n,
    voter_bist_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [3:0]  pattern;
    logic [7:0]  dwell;
    logic [4:0]  err_cnt;
    logic [15:0] fail_vec;
    logic        busy, done, pass;
    logic        last, expected, miss;
    assign {bus.a, bus.b, bus.c, bus.d} = pattern;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err_cnt;
    assign bus.fail_vec = fail_vec;
    always_comb begin
        last     = dwell == 8'(DWELL - 1);
        expected = ({2'b0, pattern[3]} + {2'b0, pattern[2]} + {2'b0, pattern[1]} + {2'b0, pattern[0]}) >= 3'd3;
        miss     = last && (bus.y != expected);
    end
    // pattern wraps 15 -> 0 as the sweep ends, so a..d read 0 outside RUN without extra gating.
    // err_cnt cannot exceed 16: at most one increment per pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pattern  <= 4'd0;
            dwell    <= 8'd0;
            err_cnt  <= 5'd0;
            fail_vec <= 16'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else if (state == RUN) begin
            dwell <= last ? 8'd0 : dwell + 8'd1;
            if (miss) begin
                err_cnt          <= err_cnt + 5'd1;
                fail_vec[pattern] <= 1'b1;
            end
            if (last)
                pattern <= pattern + 4'd1;
            if (last && pattern == 4'd15) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= err_cnt == 5'd0 && !miss;
            end
        end else begin
            state <= bus.start ? RUN : IDLE;
            busy  <= bus.start;
            done  <= 1'b0;
            pass  <= 1'b0;
            if (bus.start) begin
                pattern  <= 4'd0;
                dwell    <= 8'd0;
                err_cnt  <= 5'd0;
                fail_vec <= 16'd0;
            end
        end
    end
endmodule

// File: tb/tb_voter_bist.sv
// tb_voter_bist: scoreboard bench for voter_bist with DWELL=10 and DWELL=2 instances.
module tb_voter_bist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic glitch = 1'b0;
    int   mode = 0;
    int   tests = 0;
    int   fails = 0;
    logic [27:0] st;
    typedef struct {logic [4:0] err; logic [15:0] fv; logic ps;} res_t;
    res_t sb[$];

    always #5 clk = ~clk;

    voter_bist_if bus10();
    voter_bist_if bus2();
    voter_bist #(.DWELL(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
    voter_bist #(.DWELL(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic logic ideal(input logic [3:0] p);
        return $countones(p) >= 3;
    endfunction

    // mode 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal but inverted outside the sample cycle
    function automatic logic voter(input logic [3:0] p, input int m, input logic g);
        return m == 1 ? 1'b0 : m == 2 ? 1'b1 : ideal(p) ^ g;
    endfunction

    assign bus10.start = start & ~sel;
    assign bus2.start  = start & sel;
    assign bus10.y = voter({bus10.a, bus10.b, bus10.c, bus10.d}, mode, glitch);
    assign bus2.y  = voter({bus2.a, bus2.b, bus2.c, bus2.d}, mode, glitch);

    always_comb
        st = sel ? {bus2.busy, bus2.done, bus2.pass, bus2.err_cnt, bus2.fail_vec, bus2.a, bus2.b, bus2.c, bus2.d}
                 : {bus10.busy, bus10.done, bus10.pass, bus10.err_cnt, bus10.fail_vec, bus10.a, bus10.b, bus10.c, bus10.d};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_expected();
        res_t r;
        logic yv;
        r.err = 5'd0;
        r.fv  = 16'd0;
        for (int p = 0; p < 16; p++) begin
            yv = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ideal(4'(p));
            if (yv != ideal(4'(p))) begin
                r.err = r.err + 5'd1;
                r.fv[p] = 1'b1;
            end
        end
        r.ps = r.err == 5'd0;
        sb.push_back(r);
    endtask

    // Starts a sweep at the next rising edge and follows it cycle by cycle.
    // t counts edges after the start edge; abort_at > 0 pulses reset at that point.
    task automatic sweep(input bit hold, input int abort_at);
        int   d;
        res_t r;
        d = sel ? 2 : 10;
        r.err = 5'd0;
        r.fv  = 16'd0;
        r.ps  = 1'b0;
        start = 1'b1;
        if (abort_at == 0)
            push_expected();
        @(negedge clk);
        if (!hold)
            start = 1'b0;
        for (int t = 0; t <= 16 * d; t++) begin
            glitch = (mode == 3) && (t % d != d - 1);
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_async", 32'(st), 32'd0);
                @(negedge clk);
                check("reset_held", 32'(st), 32'd0);
                rst_n  = 1'b1;
                glitch = 1'b0;
                return;
            end
            if (t == 0)
                check("entry_cleared", 32'(st[24:4]), 32'd0);
            if (t < 16 * d) begin
                check("run", 32'({st[27:26], st[3:0]}), 32'({2'b10, 4'(t / d)}));
                @(negedge clk);
            end else begin
                check("done_latency", 32'(st[27:26]), 32'b01);
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'(sb.size()));
                end else begin
                    r = sb.pop_front();
                    check("err_cnt", 32'(st[24:20]), 32'(r.err));
                    check("fail_vec", 32'(st[19:4]), 32'(r.fv));
                    check("pass", 32'(st[25]), 32'(r.ps));
                    check("pattern_done", 32'(st[3:0]), 32'd0);
                end
            end
        end
        glitch = 1'b0;
        if (!hold) begin
            @(negedge clk);
            check("idle_flags", 32'(st[27:25]), 32'd0);
            check("held_err", 32'(st[24:20]), 32'(r.err));
            check("held_fv", 32'(st[19:4]), 32'(r.fv));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset10", 32'(st), 32'd0);
        sel = 1'b1;
        #1;
        check("reset2", 32'(st), 32'd0);
        sel = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_wait", 32'(st), 32'd0);
        mode = 0; sweep(0, 0);
        mode = 1; sweep(0, 0);
        mode = 2; sweep(0, 0);
        mode = 3; sweep(0, 0);
        mode = 0; sweep(0, 50);
        repeat (2) @(negedge clk);
        check("after_abort", 32'(st), 32'd0);
        sweep(0, 0);
        mode = 1; sweep(1, 0);
        mode = 0; sweep(1, 0);
        mode = 2; sweep(0, 0);
        sel = 1'b1;
        mode = 0; sweep(0, 0);
        mode = 1; sweep(0, 0);
        mode = 3; sweep(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/voter_bist.md
VOTER_BIST -- requirements
Module: voter_bist

Interface
- Parameter
  - REQ-001 The block SHALL have parameter DWELL, default 10, meaning clock cycles each input pattern is held (10 cycles = 100 ns at 100 MHz); legal range 2..255.
- Clock and reset
  - REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
  - REQ-003 clk  input  1  system clock; all state changes on the rising edge.
  - REQ-004 rst_n  input  1  asynchronous active-low reset.
- Control
  - REQ-005 start  input  1  level-sampled request to begin a self-test sweep.
- Stimulus to the voter under test
  - REQ-006 a  output  1  voter input a; pattern MSB.
  - REQ-007 b  output  1  voter input b.
  - REQ-008 c  output  1  voter input c.
  - REQ-009 d  output  1  voter input d; pattern LSB.
- Response from the voter under test
  - REQ-010 y  input  1  voter output under test.
- Status
  - REQ-011 busy  output  1  sweep in progress.
  - REQ-012 done  output  1  sweep complete; results valid.
  - REQ-013 pass  output  1  done with zero mismatches.
  - REQ-014 err_cnt  output  5  count of mismatching patterns, 0..16.
  - REQ-015 fail_vec  output  16  bit i set iff pattern i mismatched.

Function
- FSM
  - REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
  - REQ-017 IDLE -> RUN on a rising edge where start=1.
  - REQ-018 On entering RUN, the block SHALL set pattern=0, dwell counter=0, err_cnt=0 and fail_vec=0.
  - REQ-019 In RUN, the block SHALL drive {a,b,c,d} = pattern (4-bit, 0..15); in IDLE and DONE, {a,b,c,d} = 0.
  - REQ-020 The dwell counter SHALL increment every cycle in RUN.
  - REQ-021 At the edge where dwell counter = DWELL-1, the block SHALL sample y and compare it with expected = (popcount(pattern) >= 3).
  - REQ-022 On a mismatch at that edge: err_cnt += 1 and fail_vec[pattern] = 1, in the same edge.
  - REQ-023 At that same edge, if pattern < 15: pattern += 1 and dwell counter = 0; if pattern = 15: RUN -> DONE.
- Latency
  - REQ-024 done SHALL rise exactly 16*DWELL cycles after the start edge (160 cycles at default).
- Status outputs
  - REQ-025 busy SHALL be 1 only in RUN.
  - REQ-026 done SHALL be 1 only in DONE.
  - REQ-027 pass SHALL equal done AND (err_cnt = 0).
  - REQ-028 err_cnt and fail_vec SHALL hold their values in DONE and IDLE until the next RUN entry.
- Boundary conditions
  - REQ-029 start=1 while in RUN SHALL be ignored; the sweep is not restarted or extended.
  - REQ-030 DONE -> RUN on an edge with start=1; results are cleared per REQ-018.
  - REQ-031 With start held high continuously, the block SHALL run back-to-back sweeps, with DONE lasting one cycle each time.
  - REQ-032 DONE -> IDLE on an edge with start=0.
  - REQ-033 err_cnt SHALL saturate by construction at 16 and never wrap.
  - REQ-034 y SHALL be ignored in every cycle except the sample cycle.

Reset
- REQ-035 While rst_n=0, regardless of clk, the block SHALL be in IDLE with pattern=0, dwell counter=0, a=b=c=d=0, busy=0, done=0, pass=0, err_cnt=0 and fail_vec=0.
- REQ-036 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained.
- REQ-037 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
- REQ-038 Ideal 4-input majority model (y = popcount>=3) on {a,b,c,d}, DWELL=10, one-cycle start pulse -> a..d step through 0..15, each held 10 cycles; done rises 160 cycles after start; err_cnt=0, fail_vec=16'h0000, pass=1.
- REQ-039 y stuck at 0 -> err_cnt=5, fail_vec=16'hE880, pass=0.
- REQ-040 y stuck at 1 -> err_cnt=11, fail_vec=16'h177F, pass=0.
- REQ-041 rst_n pulsed low 50 cycles into a sweep -> all outputs 0 immediately (asynchronously); a new start then yields a full 160-cycle sweep with a correct result.
- REQ-042 start held high through RUN and DONE -> no restart mid-sweep; done is high for one cycle, then the next sweep begins with err_cnt cleared to 0.
- REQ-043 DWELL=2 with the ideal model -> done 32 cycles after start; pass=1.
